brushless_ctrl: RTL and testbench

- Commutation and drive scheduler for the 3-phase motor drive: converts Hall-sensor rotor position, brake request and drive magnitude into per-phase 2-bit select codes and an 11-bit PWM duty.
- Sits between the torque/assist computation (source of drv_mag) and the motor drive (consumer of selGrn/selYlw/selBlu/duty).
- All updates are aligned to PWM period boundaries (PWM_synch), so phase switching never happens mid-period.

---
 rtl/brushless_ctrl_if.sv | 28 ++
 rtl/brushless_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_brushless_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/brushless_ctrl_if.sv
// Bundles the inputs and outputs of the brushless_ctrl commutation scheduler.
// The master side is the torque/assist logic plus the Hall sensors.
// The slave side is the brushless_ctrl scheduler itself.
interface brushless_ctrl_if;
  logic        hallGrn;
  logic        hallYlw;
  logic        hallBlu;
  logic        brake_n;
  logic [11:0] drv_mag;
  logic        PWM_synch;
  logic        clr_fault;
  logic [1:0]  selGrn;
  logic [1:0]  selYlw;
  logic [1:0]  selBlu;
  logic [10:0] duty;
  logic [2:0]  rot_state;
  logic        fault;

  modport master (
    output hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch, clr_fault,
    input  selGrn, selYlw, selBlu, duty, rot_state, fault
  );

  modport slave (
    input  hallGrn, hallYlw, hallBlu, brake_n, drv_mag, PWM_synch, clr_fault,
    output selGrn, selYlw, selBlu, duty, rot_state, fault
  );
endinterface

// File: rtl/brushless_ctrl.sv
// 3-phase commutation and drive scheduler.
// It turns Hall rotor position, a brake request and a drive magnitude into
// per-phase select codes and a PWM duty. Every decision is aligned to a PWM
// period boundary: rot_state is captured on PWM_synch, and the outputs are
// registered on the following cycle.
// Optional feature: define HALL_SEQ_CHK_EN to flag illegal Hall sequence jumps
// that happen while running.
module brushless_ctrl #(
  parameter logic [10:0] MIN_DUTY   = 11'h400,
  parameter logic [10:0] BRAKE_DUTY = 11'h600,
  parameter logic [10:0] RAMP_STEP  = 11'd16,
  parameter int unsigned FAULT_CNT  = 3
) (
  input logic clk,
  input logic rst_n,
  brushless_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, BRAKE, FAULT} state_t;

  localparam logic [1:0] SEL_Z   = 2'b00;
  localparam logic [1:0] SEL_REV = 2'b01;
  localparam logic [1:0] SEL_FWD = 2'b10;
  localparam logic [1:0] SEL_BRK = 2'b11;

  // Phase selects {G,Y,B} for each rotor position; invalid codes float all phases.
  function automatic logic [5:0] comm(input logic [2:0] r);
    case (r)
      3'b101:  comm = {SEL_FWD, SEL_REV, SEL_Z};
      3'b100:  comm = {SEL_FWD, SEL_Z, SEL_REV};
      3'b110:  comm = {SEL_Z, SEL_FWD, SEL_REV};
      3'b010:  comm = {SEL_REV, SEL_FWD, SEL_Z};
      3'b011:  comm = {SEL_REV, SEL_Z, SEL_FWD};
      3'b001:  comm = {SEL_Z, SEL_REV, SEL_FWD};
      default: comm = {SEL_Z, SEL_Z, SEL_Z};
    endcase
  endfunction

  logic [2:0]  hall_meta, hall_sync, rot_q;
  logic        synch_d, clr_req, clr_pend;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic [10:0] ramp_q, ramp_d, duty_q, duty_d, tgt;
  logic [11:0] tgt_wide;
  logic [1:0]  sel_g_q, sel_y_q, sel_b_q, sel_g_d, sel_y_d, sel_b_d;
  logic        fault_q, fault_d;
  logic        invalid, seq_bad, bad_sample;
  logic [5:0]  comm_sel;

  // Synchronize the Halls, capture rotor position and track the fault-clear request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so that every flop
    // samples its pre-edge value, which keeps the two-flop synchronizer two flops deep.
    if (!rst_n) begin
      hall_meta <= '0;
      hall_sync <= '0;
      rot_q     <= '0;
      synch_d   <= 1'b0;
      clr_req   <= 1'b0;
    end else begin
      hall_meta <= {bus.hallGrn, bus.hallYlw, bus.hallBlu};
      hall_sync <= hall_meta;
      synch_d   <= bus.PWM_synch;
      if (bus.PWM_synch) rot_q <= hall_sync;
      if (synch_d)            clr_req <= 1'b0;
      else if (bus.clr_fault) clr_req <= 1'b1;
    end
  end

  assign clr_pend = clr_req | bus.clr_fault;
  assign invalid  = (rot_q == 3'b000) || (rot_q == 3'b111);
  assign comm_sel = comm(rot_q);
  assign cnt_inc  = cnt_q + 3'd1;

  // Saturating target duty: offset plus the scaled magnitude.
  assign tgt_wide = {1'b0, MIN_DUTY} + {2'b00, bus.drv_mag[11:2]};
  assign tgt      = tgt_wide[11] ? 11'h7FF : tgt_wide[10:0];

`ifdef HALL_SEQ_CHK_EN
  logic [2:0] prev_q;
  logic       prev_vld;
  logic [3:0] step;

  // Position of a Hall code in the rotation order 101-100-110-010-011-001.
  function automatic logic [3:0] seq_idx(input logic [2:0] r);
    case (r)
      3'b101:  seq_idx = 4'd0;
      3'b100:  seq_idx = 4'd1;
      3'b110:  seq_idx = 4'd2;
      3'b010:  seq_idx = 4'd3;
      3'b011:  seq_idx = 4'd4;
      default: seq_idx = 4'd5;
    endcase
  endfunction

  // Remember the last valid rotor position seen at a decision point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= '0;
      prev_vld <= 1'b0;
    end else if (synch_d && !invalid) begin
      prev_q   <= rot_q;
      prev_vld <= 1'b1;
    end
  end

  // In RUN, a valid code that is neither the same as nor a neighbour of the previous one is illegal.
  always_comb begin
    step = (seq_idx(rot_q) >= seq_idx(prev_q)) ? seq_idx(rot_q) - seq_idx(prev_q)
                                               : seq_idx(rot_q) + 4'd6 - seq_idx(prev_q);
    seq_bad = (state_q == RUN) && !invalid && prev_vld &&
              !((step == 4'd0) || (step == 4'd1) || (step == 4'd5));
  end
`else
  assign seq_bad = 1'b0;
`endif

  assign bad_sample = invalid | seq_bad;

  // Next state, counter, ramp and output values, applied only at a decision point.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    ramp_d  = 11'd0;
    duty_d  = 11'd0;
    sel_g_d = SEL_Z;
    sel_y_d = SEL_Z;
    sel_b_d = SEL_Z;
    fault_d = 1'b0;

    if (state_q == FAULT) begin
      if (clr_pend && !invalid) begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    end else begin
      if (bad_sample) cnt_d = cnt_inc;
      else            cnt_d = 3'd0;
      if (bad_sample && (cnt_inc >= 3'(FAULT_CNT))) state_d = FAULT;
      else if (!bus.brake_n)                        state_d = BRAKE;
      else if (bus.drv_mag != 12'd0)                state_d = RUN;
      else                                          state_d = IDLE;
    end

    case (state_d)
      RUN: begin
        if (tgt > ramp_q) ramp_d = ((tgt - ramp_q) > RAMP_STEP) ? ramp_q + RAMP_STEP : tgt;
        else              ramp_d = tgt;
        duty_d = ramp_d;
        {sel_g_d, sel_y_d, sel_b_d} = comm_sel;
      end
      BRAKE: begin
        duty_d  = BRAKE_DUTY;
        sel_g_d = SEL_BRK;
        sel_y_d = SEL_BRK;
        sel_b_d = SEL_BRK;
      end
      FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  // Registered FSM and outputs; these update only on the cycle after PWM_synch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ramp_q  <= '0;
      duty_q  <= '0;
      sel_g_q <= SEL_Z;
      sel_y_q <= SEL_Z;
      sel_b_q <= SEL_Z;
      fault_q <= 1'b0;
    end else if (synch_d) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ramp_q  <= ramp_d;
      duty_q  <= duty_d;
      sel_g_q <= sel_g_d;
      sel_y_q <= sel_y_d;
      sel_b_q <= sel_b_d;
      fault_q <= fault_d;
    end
  end

  assign bus.selGrn    = sel_g_q;
  assign bus.selYlw    = sel_y_q;
  assign bus.selBlu    = sel_b_q;
  assign bus.duty      = duty_q;
  assign bus.rot_state = rot_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_brushless_ctrl.sv
// Self-checking bench for brushless_ctrl.
// Expected outputs go into a scoreboard queue each time a PWM_synch pulse is
// issued. A monitor pops them and compares them with the outputs two clocks later.
`timescale 1ns/1ps
module tb_brushless_ctrl;

  typedef struct {
    logic [1:0]  g;
    logic [1:0]  y;
    logic [1:0]  b;
    logic [10:0] duty;
    logic        fault;
    logic [2:0]  rot;
  } exp_t;

  typedef struct {
    logic [2:0]  hall;
    logic        brake_n;
    logic [11:0] drv;
    exp_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  vec_t vecs[13];

  brushless_ctrl_if bus();

  brushless_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] g, input logic [1:0] y, input logic [1:0] b,
                              input logic [10:0] duty, input logic fault);
    exp_t e;
    e.g = g; e.y = y; e.b = b; e.duty = duty; e.fault = fault; e.rot = 3'b000;
    return e;
  endfunction

  function automatic vec_t row(input logic [2:0] hall, input logic brake_n,
                               input logic [11:0] drv, input exp_t e);
    vec_t v;
    v.hall = hall; v.brake_n = brake_n; v.drv = drv; v.exp = e;
    return v;
  endfunction

  function automatic logic [10:0] min11(input int a, input int b);
    return (a < b) ? 11'(a) : 11'(b);
  endfunction

  task automatic set_in(input logic [2:0] hall, input logic brake_n, input logic [11:0] drv);
    {bus.hallGrn, bus.hallYlw, bus.hallBlu} = hall;
    bus.brake_n = brake_n;
    bus.drv_mag = drv;
  endtask

  // Let the Halls settle through the synchronizer, queue the expectation, then pulse PWM_synch.
  task automatic pulse(input exp_t e);
    exp_t q;
    q = e;
    q.rot = {bus.hallGrn, bus.hallYlw, bus.hallBlu};
    repeat (4) @(negedge clk);
    sb_q.push_back(q);
    bus.PWM_synch = 1'b1;
    @(negedge clk);
    bus.PWM_synch = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Monitor: outputs must show the expected result two edges after PWM_synch is sampled.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.PWM_synch === 1'b1 && rst_n === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("selGrn", 32'(bus.selGrn), 32'(e.g));
          check("selYlw", 32'(bus.selYlw), 32'(e.y));
          check("selBlu", 32'(bus.selBlu), 32'(e.b));
          check("duty", 32'(bus.duty), 32'(e.duty));
          check("fault", 32'(bus.fault), 32'(e.fault));
          check("rot_state", 32'(bus.rot_state), 32'(e.rot));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    localparam logic [1:0] Z = 2'b00, R = 2'b01, F = 2'b10, B = 2'b11;
    vecs[0]  = row(3'b100, 1'b1, 12'h800, mk(F, Z, R, 11'h600, 1'b0));
    vecs[1]  = row(3'b110, 1'b1, 12'h800, mk(Z, F, R, 11'h600, 1'b0));
    vecs[2]  = row(3'b010, 1'b1, 12'h800, mk(R, F, Z, 11'h600, 1'b0));
    vecs[3]  = row(3'b011, 1'b1, 12'h800, mk(R, Z, F, 11'h600, 1'b0));
    vecs[4]  = row(3'b001, 1'b1, 12'h800, mk(Z, R, F, 11'h600, 1'b0));
    vecs[5]  = row(3'b101, 1'b1, 12'h800, mk(F, R, Z, 11'h600, 1'b0));
    vecs[6]  = row(3'b101, 1'b1, 12'h100, mk(F, R, Z, 11'h440, 1'b0));
    vecs[7]  = row(3'b101, 1'b0, 12'h100, mk(B, B, B, 11'h600, 1'b0));
    vecs[8]  = row(3'b100, 1'b0, 12'h100, mk(B, B, B, 11'h600, 1'b0));
    vecs[9]  = row(3'b100, 1'b1, 12'h100, mk(F, Z, R, 11'd16,  1'b0));
    vecs[10] = row(3'b100, 1'b1, 12'h000, mk(Z, Z, Z, 11'd0,   1'b0));
    vecs[11] = row(3'b100, 1'b1, 12'h100, mk(F, Z, R, 11'd16,  1'b0));
    vecs[12] = row(3'b110, 1'b1, 12'h100, mk(Z, F, R, 11'd32,  1'b0));

    bus.PWM_synch = 1'b0;
    bus.clr_fault = 1'b0;
    set_in(3'b000, 1'b1, 12'h000);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_selGrn", 32'(bus.selGrn), 32'd0);
    check("rst_selYlw", 32'(bus.selYlw), 32'd0);
    check("rst_selBlu", 32'(bus.selBlu), 32'd0);
    check("rst_duty", 32'(bus.duty), 32'd0);
    check("rst_rot", 32'(bus.rot_state), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    rst_n = 1'b1;

    // Ramp up toward 0x600 from IDLE in steps of 16, then hold.
    set_in(3'b101, 1'b1, 12'h800);
    for (int k = 1; k <= 98; k++) pulse(mk(F, R, Z, min11(16 * k, 'h600), 1'b0));

    // A Hall change between pulses must not reach the outputs.
    set_in(3'b100, 1'b1, 12'h800);
    repeat (8) @(negedge clk);
    check("hold_rot", 32'(bus.rot_state), 32'b101);
    check("hold_selGrn", 32'(bus.selGrn), 32'(F));
    check("hold_selBlu", 32'(bus.selBlu), 32'(Z));
    check("hold_duty", 32'(bus.duty), 32'h600);

    // Commutation table, ramp-down, brake and idle transitions.
    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].hall, vecs[i].brake_n, vecs[i].drv);
      pulse(vecs[i].exp);
    end

    // Continue the ramp toward 0x440 and hold there.
    for (int k = 3; k <= 70; k++) pulse(mk(Z, F, R, min11(16 * k, 'h440), 1'b0));

    // An invalid sample in RUN floats the phases; the next valid sample restores them.
    set_in(3'b111, 1'b1, 12'h100);
    pulse(mk(Z, Z, Z, 11'h440, 1'b0));
    set_in(3'b110, 1'b1, 12'h100);
    pulse(mk(Z, F, R, 11'h440, 1'b0));

    // Brake together with invalid samples: stay in BRAKE until the third invalid sample.
    set_in(3'b111, 1'b0, 12'h100);
    pulse(mk(B, B, B, 11'h600, 1'b0));
    pulse(mk(B, B, B, 11'h600, 1'b0));
    pulse(mk(Z, Z, Z, 11'd0, 1'b1));
    pulse(mk(Z, Z, Z, 11'd0, 1'b1));

    // A fault clear seen with an invalid Hall code is ignored.
    set_in(3'b000, 1'b0, 12'h100);
    @(negedge clk);
    bus.clr_fault = 1'b1;
    @(negedge clk);
    bus.clr_fault = 1'b0;
    pulse(mk(Z, Z, Z, 11'd0, 1'b1));

    // A fault clear held sticky into a valid sample returns to IDLE.
    set_in(3'b110, 1'b0, 12'h100);
    @(negedge clk);
    bus.clr_fault = 1'b1;
    @(negedge clk);
    bus.clr_fault = 1'b0;
    pulse(mk(Z, Z, Z, 11'd0, 1'b0));
    pulse(mk(B, B, B, 11'h600, 1'b0));

    // Leave BRAKE into RUN, then reset mid-ramp between pulses.
    set_in(3'b110, 1'b1, 12'h800);
    pulse(mk(Z, F, R, 11'd16, 1'b0));
    pulse(mk(Z, F, R, 11'd32, 1'b0));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_selGrn", 32'(bus.selGrn), 32'd0);
    check("midrst_selYlw", 32'(bus.selYlw), 32'd0);
    check("midrst_selBlu", 32'(bus.selBlu), 32'd0);
    check("midrst_duty", 32'(bus.duty), 32'd0);
    check("midrst_rot", 32'(bus.rot_state), 32'd0);
    check("midrst_fault", 32'(bus.fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Repeated 101 <-> 110 jumps: these are illegal only with the sequence check enabled.
    set_in(3'b101, 1'b1, 12'h800);
    pulse(mk(F, R, Z, 11'd16, 1'b0));
    set_in(3'b110, 1'b1, 12'h800);
    pulse(mk(Z, F, R, 11'd32, 1'b0));
    set_in(3'b101, 1'b1, 12'h800);
    pulse(mk(F, R, Z, 11'd48, 1'b0));
    set_in(3'b110, 1'b1, 12'h800);
`ifdef HALL_SEQ_CHK_EN
    pulse(mk(Z, Z, Z, 11'd0, 1'b1));
`else
    pulse(mk(Z, F, R, 11'd64, 1'b0));
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
